// File: rtl/mc_bus_responder.sv
// mc_bus_responder: FPGA-side responder for the MCU parallel memory bus.
// Synchronises MCU strobes, decodes register/command/FIFO accesses.

// Small first-word-fall-through FIFO used for both the TX and RX paths.
module mc_bus_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic [7:0]   count,
    output logic         drop
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          pop_ok;
    logic          push_ok;

    // A pop on empty is ignored; a push on full only lands if a pop frees a slot
    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !push_ok;
    assign dout    = mem[rd_ptr];
    assign count   = 8'(cnt);

    // Storage array, written on accepted pushes only
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

module mc_bus_responder #(
    parameter int MC_DATA_WIDTH = 16,
    parameter int MC_ADD_WIDTH  = 6,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        mc_ce,
    input  logic                        mc_we,
    input  logic                        mc_oe,
    input  logic [MC_ADD_WIDTH-1:0]     mc_add,
    inout  wire  [MC_DATA_WIDTH-1:0]    mc_data,
    output logic [16*MC_DATA_WIDTH-1:0] reg_q,
    output logic [15:0]                 reg_wr_stb,
    output logic                        cmd_valid,
    output logic [MC_DATA_WIDTH-1:0]    cmd_data,
    output logic [MC_DATA_WIDTH-1:0]    tx_data,
    output logic                        tx_empty,
    input  logic                        tx_pop,
    input  logic [MC_DATA_WIDTH-1:0]    rx_data,
    input  logic                        rx_push,
    output logic                        rx_full,
    output logic                        irq
);
    localparam int W = MC_DATA_WIDTH;
    localparam int A = MC_ADD_WIDTH;

    localparam logic [A-1:0] ADDR_TXD  = A'(16'h10);
    localparam logic [A-1:0] ADDR_RXD  = A'(16'h11);
    localparam logic [A-1:0] ADDR_STAT = A'(16'h12);
    localparam logic [A-1:0] ADDR_CMD  = A'(16'h19);

    logic         ce_s1, ce_s2;
    logic         we_s1, we_s2, we_s3;
    logic         oe_s1, oe_s2, oe_s3;
    logic [A-1:0] add_s1, add_s2;
    logic [W-1:0] dat_s1, dat_s2;

    logic [W-1:0] regs [16];
    logic [W-1:0] rd_latch;
    logic         rd_pop_pend;
    logic         tx_ovf, rx_udf, rx_ovf;

    logic         we_fall, oe_fall, oe_rise;
    logic         wr_go, rd_go;
    logic         add_is_reg;
    logic         wr_reg, wr_tx, wr_clr, wr_cmd;
    logic         rx_pop;
    logic         udf_set;

    logic [W-1:0] rx_head;
    logic         rx_empty;
    logic [7:0]   rx_count;
    logic         rx_drop;
    logic         tx_full;
    logic [7:0]   tx_count;
    logic         tx_drop;
    logic [15:0]  stat16;
    logic [W-1:0] status;
    logic         drive_en;

    // Two-flop synchronisers plus a third stage on we/oe for edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ce_s1  <= 1'b1;
            ce_s2  <= 1'b1;
            we_s1  <= 1'b0;
            we_s2  <= 1'b0;
            we_s3  <= 1'b0;
            oe_s1  <= 1'b1;
            oe_s2  <= 1'b1;
            oe_s3  <= 1'b1;
            add_s1 <= '0;
            add_s2 <= '0;
            dat_s1 <= '0;
            dat_s2 <= '0;
        end else begin
            ce_s1  <= mc_ce;
            ce_s2  <= ce_s1;
            we_s1  <= mc_we;
            we_s2  <= we_s1;
            we_s3  <= we_s2;
            oe_s1  <= mc_oe;
            oe_s2  <= oe_s1;
            oe_s3  <= oe_s2;
            add_s1 <= mc_add;
            add_s2 <= add_s1;
            dat_s1 <= mc_data;
            dat_s2 <= dat_s1;
        end
    end

    // Write commits on we 1->0; a read capture yields to any active write
    assign we_fall    = we_s3 && !we_s2;
    assign oe_fall    = oe_s3 && !oe_s2;
    assign oe_rise    = !oe_s3 && oe_s2;
    assign wr_go      = we_fall && !ce_s2;
    assign rd_go      = oe_fall && !ce_s2 && !we_s2 && !wr_go;
    assign add_is_reg = (add_s2[A-1:4] == '0);
    assign wr_reg     = wr_go && add_is_reg;
    assign wr_tx      = wr_go && (add_s2 == ADDR_TXD);
    assign wr_clr     = wr_go && (add_s2 == ADDR_STAT);
    assign wr_cmd     = wr_go && (add_s2 == ADDR_CMD);
    assign rx_pop     = oe_rise && rd_pop_pend;
    assign udf_set    = rx_pop && rx_empty;

    mc_bus_fifo #(
        .W     (W),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (wr_tx),
        .din   (dat_s2),
        .pop   (tx_pop),
        .dout  (tx_data),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_count),
        .drop  (tx_drop)
    );

    mc_bus_fifo #(
        .W     (W),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_push),
        .din   (rx_data),
        .pop   (rx_pop),
        .dout  (rx_head),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count),
        .drop  (rx_drop)
    );

    assign stat16 = {rx_count, 1'b0, rx_ovf, rx_udf, tx_ovf,
                     rx_empty, rx_full, tx_empty, tx_full};
    assign status = W'(stat16);

    // Configuration register file and its one-hot write strobes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
            reg_wr_stb <= '0;
        end else begin
            reg_wr_stb <= '0;
            if (wr_reg) begin
                regs[add_s2[3:0]] <= dat_s2;
                reg_wr_stb        <= 16'(1) << add_s2[3:0];
            end
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_regq
        assign reg_q[g*W +: W] = regs[g];
    end

    // Command word and its single-cycle valid pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
        end else begin
            cmd_valid <= wr_cmd;
            if (wr_cmd) begin
                cmd_data <= dat_s2;
            end
        end
    end

    // Read capture on oe assertion; remember whether oe release must pop RX
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_latch    <= '0;
            rd_pop_pend <= 1'b0;
        end else begin
            if (rd_go) begin
                rd_pop_pend <= (add_s2 == ADDR_RXD);
                if (add_is_reg) begin
                    rd_latch <= regs[add_s2[3:0]];
                end else if (add_s2 == ADDR_RXD) begin
                    rd_latch <= rx_empty ? '0 : rx_head;
                end else if (add_s2 == ADDR_STAT) begin
                    rd_latch <= status;
                end else begin
                    rd_latch <= '0;
                end
            end else if (oe_rise) begin
                rd_pop_pend <= 1'b0;
            end
        end
    end

    // Sticky error bits: W1C clear, a same-cycle set takes priority
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_ovf <= 1'b0;
            rx_udf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            tx_ovf <= (tx_ovf && !(wr_clr && dat_s2[4])) || tx_drop;
            rx_udf <= (rx_udf && !(wr_clr && dat_s2[5])) || udf_set;
            rx_ovf <= (rx_ovf && !(wr_clr && dat_s2[6])) || rx_drop;
        end
    end

    // Registered interrupt level: pending RX data or any error
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= !rx_empty || tx_ovf || rx_udf || rx_ovf;
        end
    end

    assign drive_en = !mc_oe && !mc_ce && !reset;
    assign mc_data  = drive_en ? rd_latch : 'z;
endmodule

// File: tb/tb_mc_bus_responder.sv
// tb_mc_bus_responder: directed bench for mc_bus_responder.
// Table-driven register accesses plus hand-written FIFO/timing sequences.
module tb_mc_bus_responder;
    localparam int W = 16;

    typedef struct {
        bit          is_wr;
        logic [5:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           mc_ce, mc_we, mc_oe;
    logic [5:0]     mc_add;
    wire  [W-1:0]   mc_data;
    logic [16*W-1:0] reg_q;
    logic [15:0]    reg_wr_stb;
    logic           cmd_valid;
    logic [W-1:0]   cmd_data;
    logic [W-1:0]   tx_data;
    logic           tx_empty;
    logic           tx_pop;
    logic [W-1:0]   rx_data;
    logic           rx_push;
    logic           rx_full;
    logic           irq;

    logic           den;
    logic [W-1:0]   dout;

    int checks = 0;
    int failures = 0;
    int stb0_cnt = 0;
    int cmd_cnt = 0;

    vec_t vt [13];

    assign mc_data = den ? dout : 'z;

    for (genvar i = 0; i < W; i++) begin : g_pu
        pullup (mc_data[i]);
    end

    always #5 clk = ~clk;

    mc_bus_responder #(
        .MC_DATA_WIDTH (16),
        .MC_ADD_WIDTH  (6),
        .FIFO_DEPTH    (16)
    ) dut (
        .clock      (clk),
        .reset      (rst),
        .mc_ce      (mc_ce),
        .mc_we      (mc_we),
        .mc_oe      (mc_oe),
        .mc_add     (mc_add),
        .mc_data    (mc_data),
        .reg_q      (reg_q),
        .reg_wr_stb (reg_wr_stb),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .tx_data    (tx_data),
        .tx_empty   (tx_empty),
        .tx_pop     (tx_pop),
        .rx_data    (rx_data),
        .rx_push    (rx_push),
        .rx_full    (rx_full),
        .irq        (irq)
    );

    always @(posedge clk) begin
        if (reg_wr_stb[0] === 1'b1) stb0_cnt <= stb0_cnt + 1;
        if (cmd_valid === 1'b1) cmd_cnt <= cmd_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] rq(input int n);
        return reg_q[n*W +: W];
    endfunction

    task automatic wr_start(input logic [5:0] a, input logic [15:0] d);
        @(negedge clk);
        mc_ce = 1'b0; mc_add = a; dout = d; den = 1'b1; mc_we = 1'b1;
        repeat (3) @(negedge clk);
        mc_we = 1'b0;
    endtask

    task automatic wr_finish();
        @(negedge clk);
        mc_ce = 1'b1; den = 1'b0;
    endtask

    task automatic mcu_write(input logic [5:0] a, input logic [15:0] d);
        wr_start(a, d);
        repeat (4) @(posedge clk);
        wr_finish();
    endtask

    // Write and sample the strobes 1ns after the 3rd and 4th edges
    task automatic wr_pulse(input logic [5:0] a, input logic [15:0] d,
                            output logic [15:0] s3, output logic c3,
                            output logic [15:0] s4, output logic c4);
        wr_start(a, d);
        repeat (3) @(posedge clk);
        #1; s3 = reg_wr_stb; c3 = cmd_valid;
        @(posedge clk);
        #1; s4 = reg_wr_stb; c4 = cmd_valid;
        wr_finish();
    endtask

    task automatic rd_capture(input logic [5:0] a, output logic [15:0] d);
        @(negedge clk);
        mc_ce = 1'b0; mc_add = a; mc_oe = 1'b0;
        repeat (5) @(negedge clk);
        d = mc_data;
    endtask

    // Release oe; optionally push RX in the same cycle as the pop edge
    task automatic rd_release(input bit push, input logic [15:0] v);
        mc_oe = 1'b1; mc_ce = 1'b1;
        repeat (2) @(negedge clk);
        if (push) begin
            rx_push = 1'b1; rx_data = v;
        end
        @(negedge clk);
        rx_push = 1'b0;
        @(negedge clk);
    endtask

    task automatic mcu_read(input logic [5:0] a, output logic [15:0] d);
        rd_capture(a, d);
        rd_release(1'b0, 16'h0);
    endtask

    task automatic pop_tx();
        @(negedge clk);
        tx_pop = 1'b1;
        @(negedge clk);
        tx_pop = 1'b0;
    endtask

    initial begin
        logic [15:0] rd, s3, s4;
        logic c3, c4;
        logic [15:0] txw [3];
        rst = 1'b1; mc_ce = 1'b1; mc_we = 1'b0; mc_oe = 1'b1;
        mc_add = '0; den = 1'b0; dout = '0;
        tx_pop = 1'b0; rx_push = 1'b0; rx_data = '0;

        vt[0]  = '{1'b1, 6'h01, 16'h1234, 16'h1234};
        vt[1]  = '{1'b1, 6'h05, 16'hABCD, 16'hABCD};
        vt[2]  = '{1'b1, 6'h0F, 16'hFFFF, 16'hFFFF};
        vt[3]  = '{1'b1, 6'h0F, 16'h8001, 16'h8001};
        vt[4]  = '{1'b0, 6'h01, 16'h0000, 16'h1234};
        vt[5]  = '{1'b0, 6'h05, 16'h0000, 16'hABCD};
        vt[6]  = '{1'b0, 6'h0F, 16'h0000, 16'h8001};
        vt[7]  = '{1'b0, 6'h00, 16'h0000, 16'h00FF};
        vt[8]  = '{1'b0, 6'h20, 16'h0000, 16'h0000};
        vt[9]  = '{1'b0, 6'h13, 16'h0000, 16'h0000};
        vt[10] = '{1'b0, 6'h3F, 16'h0000, 16'h0000};
        vt[11] = '{1'b0, 6'h19, 16'h0000, 16'h0000};
        vt[12] = '{1'b0, 6'h12, 16'h0000, 16'h000A};

        repeat (3) @(negedge clk);
        check("rst_regq", 32'(reg_q == '0), 32'd1);
        check("rst_tx_empty", 32'(tx_empty), 32'd1);
        check("rst_rx_full", 32'(rx_full), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_stb", 32'(reg_wr_stb), 32'd0);
        check("rst_cmd", 32'({cmd_valid, cmd_data}), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_bus_hiz", 32'(mc_data), 32'hFFFF);

        // First write with exact commit timing
        wr_start(6'h00, 16'h0055);
        repeat (2) @(posedge clk);
        #1 check("wr0_before_commit", 32'(rq(0)), 32'h0);
        @(posedge clk);
        #1 check("wr0_commit", 32'(rq(0)), 32'h0055);
        check("wr0_stb_hi", 32'(reg_wr_stb), 32'h0001);
        @(posedge clk);
        #1 check("wr0_stb_lo", 32'(reg_wr_stb), 32'h0);
        wr_finish();
        wr_pulse(6'h00, 16'h00FF, s3, c3, s4, c4);
        check("wr1_val", 32'(rq(0)), 32'h00FF);
        check("wr1_stb", 32'({s3, s4}), 32'h0001_0000);
        check("stb0_count", 32'(stb0_cnt), 32'd2);

        for (int i = 0; i < 13; i++) begin
            if (vt[i].is_wr) begin
                mcu_write(vt[i].addr, vt[i].data);
                check($sformatf("vec%0d_wr", i),
                      32'(rq(int'(vt[i].addr[3:0]))), 32'(vt[i].exp));
            end else begin
                mcu_read(vt[i].addr, rd);
                check($sformatf("vec%0d_rd", i), 32'(rd), 32'(vt[i].exp));
            end
        end

        wr_pulse(6'h19, 16'h0002, s3, c3, s4, c4);
        check("cmd2", 32'({c3, c4, cmd_data}), 32'h2_0002);
        wr_pulse(6'h19, 16'h0001, s3, c3, s4, c4);
        check("cmd1", 32'({c3, c4, cmd_data}), 32'h2_0001);
        wr_pulse(6'h19, 16'h0003, s3, c3, s4, c4);
        check("cmd3", 32'({c3, c4, cmd_data}), 32'h2_0003);
        check("cmd_no_stb", 32'({s3, s4}), 32'h0);
        check("cmd_count", 32'(cmd_cnt), 32'd3);
        check("cmd_regq", 32'({rq(0), rq(15)}), 32'h00FF_8001);

        txw[0] = 16'h1111; txw[1] = 16'h2222; txw[2] = 16'h3333;
        for (int i = 0; i < 3; i++) mcu_write(6'h10, txw[i]);
        check("tx_nonempty", 32'(tx_empty), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("tx_head%0d", i), 32'(tx_data), 32'(txw[i]));
            pop_tx();
        end
        check("tx_drained", 32'(tx_empty), 32'd1);
        for (int i = 0; i < 17; i++) mcu_write(6'h10, 16'h4000 + 16'(i));
        mcu_read(6'h12, rd);
        check("tx_full_status", 32'(rd), 32'h0019);
        check("tx_ovf_irq", 32'(irq), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("tx_fill%0d", i), 32'(tx_data),
                  32'h4000 + 32'(i));
            pop_tx();
        end
        check("tx_17th_dropped", 32'(tx_empty), 32'd1);
        mcu_write(6'h12, 16'h0010);
        check("tx_ovf_clr_irq", 32'(irq), 32'd0);

        @(negedge clk);
        rx_push = 1'b1; rx_data = 16'hA5A5;
        @(negedge clk);
        rx_data = 16'h5A5A;
        @(negedge clk);
        rx_push = 1'b0;
        repeat (2) @(negedge clk);
        check("rx_irq", 32'(irq), 32'd1);
        mcu_read(6'h11, rd);
        check("rx_rd0", 32'(rd), 32'hA5A5);
        mcu_read(6'h11, rd);
        check("rx_rd1", 32'(rd), 32'h5A5A);
        mcu_read(6'h12, rd);
        check("rx_empty_status", 32'(rd), 32'h000A);
        check("rx_irq_clr", 32'(irq), 32'd0);
        mcu_read(6'h11, rd);
        check("rx_udf_rd", 32'(rd), 32'h0);
        mcu_read(6'h12, rd);
        check("rx_udf_status", 32'(rd), 32'h002A);
        check("rx_udf_irq", 32'(irq), 32'd1);
        mcu_write(6'h12, 16'h0020);
        mcu_read(6'h12, rd);
        check("rx_udf_clr", 32'({rd, 15'h0, irq}), 32'h000A_0000);

        @(negedge clk);
        rx_push = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_data = 16'h0100 + 16'(i);
            @(negedge clk);
        end
        rx_push = 1'b0;
        check("rx_full", 32'(rx_full), 32'd1);
        mcu_read(6'h12, rd);
        check("rx_full_status", 32'(rd), 32'h1006);
        rd_capture(6'h11, rd);
        check("rx_full_head", 32'(rd), 32'h0100);
        rd_release(1'b1, 16'hBEEF);
        mcu_read(6'h12, rd);
        check("rx_pushpop_full", 32'(rd), 32'h1006);
        @(negedge clk);
        rx_push = 1'b1; rx_data = 16'hDEAD;
        @(negedge clk);
        rx_push = 1'b0;
        mcu_read(6'h12, rd);
        check("rx_ovf_status", 32'(rd), 32'h1046);

        wr_start(6'h03, 16'h7777);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; mc_oe = 1'b0; den = 1'b0;
        @(negedge clk);
        check("midrst_bus_hiz", 32'(mc_data), 32'hFFFF);
        check("midrst_flags", 32'({tx_empty, rx_full, irq, cmd_valid}),
              32'b1000);
        mc_oe = 1'b1; mc_ce = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst_no_commit", 32'(reg_q == '0), 32'd1);
        check("midrst_no_stb", 32'(reg_wr_stb), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
